reg_scoreboard: RTL

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard_if.sv | 28 ++
 rtl/reg_scoreboard.sv | 88 ++++++++
 2 files changed

// File: rtl/reg_scoreboard_if.sv
// Issue/retire/query bundle between the ID stage and the register write scoreboard.
interface reg_scoreboard_if;
  logic       issue_valid;
  logic [2:0] issue_rd;
  logic       issue_wb_en;
  logic       retire_valid;
  logic [2:0] retire_rd;
  logic       flush;
  logic       drain_req;
  logic [2:0] rs1;
  logic [2:0] rs2;
  logic [7:0] busy;
  logic       stall;
  logic       drain_done;
  logic       err;

  modport master (
    output issue_valid, issue_rd, issue_wb_en, retire_valid, retire_rd,
           flush, drain_req, rs1, rs2,
    input  busy, stall, drain_done, err
  );

  modport slave (
    input  issue_valid, issue_rd, issue_wb_en, retire_valid, retire_rd,
           flush, drain_req, rs1, rs2,
    output busy, stall, drain_done, err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters for registers 1..7, with RAW stall
// generation and a RUN/DRAIN/DONE sequencer for emptying outstanding writes.
module reg_scoreboard #(
    parameter int unsigned CNT_W = 2
) (
    input logic            clk,
    input logic            rst,
    reg_scoreboard_if.slave sb
);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt [1:7];
    logic [7:0]       busy;
    logic [7:0]       inc_vec;
    logic [7:0]       dec_vec;
    logic             stall;
    logic             err_q;
    logic             all_zero;

    always_comb begin
        busy = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            busy[i] = (cnt[i] != '0);
        end
    end

    assign all_zero = (busy[7:1] == 7'd0);

    always_comb begin
        stall = ((sb.rs1 != 3'd0) && busy[sb.rs1]) ||
                ((sb.rs2 != 3'd0) && busy[sb.rs2]) ||
                (state == DRAIN);
    end

    // One-hot increment/decrement requests; bit 0 is always masked off.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (sb.issue_valid && sb.issue_wb_en && (sb.issue_rd != 3'd0) && !stall)
            inc_vec = 8'b1 << sb.issue_rd;
        if (sb.retire_valid && (sb.retire_rd != 3'd0))
            dec_vec = 8'b1 << sb.retire_rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 1; i < 8; i++) cnt[i] <= '0;
            err_q <= 1'b0;
        end else if (sb.flush) begin
            for (int unsigned i = 1; i < 8; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 1; i < 8; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    if (cnt[i] == CNT_MAX) err_q   <= 1'b1;
                    else                   cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    if (cnt[i] == '0) err_q   <= 1'b1;
                    else              cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (sb.drain_req) state_nx = DRAIN;
            DRAIN:   if (all_zero || sb.flush) state_nx = DONE;
            DONE:    state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    assign sb.busy       = busy;
    assign sb.stall      = stall;
    assign sb.drain_done = (state == DONE);
    assign sb.err        = err_q;

endmodule
